bcd_serial_converter: RTL and testbench

- Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") for the display path.
- Takes an unsigned value of up to 6 bits and produces registered tens and ones BCD digits for the seven-segment decoder stage directly downstream.
- Replaces the combinational divide/modulo in front of the two-digit display with a small FSM and a start/busy/done handshake.
- Value range 0..63, so two BCD digits always suffice.

---
 rtl/bcd_serial_converter.sv | 116 +++++++++++
 tb/tb_bcd_serial_converter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3) producing registered
// tens/ones digits for a two-digit display, with a start/busy/done handshake.
module bcd_serial_converter #(
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [7:0]       bcd_q, bcd_d;
    logic [2:0]       count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;

    logic [3:0]       hi_corr;
    logic [3:0]       lo_corr;
    logic [7:0]       bcd_next;

    always_comb begin
        // Tens nibble stays below 8 for inputs up to 63, so its MSB is dropped on shift.
        hi_corr  = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
        lo_corr  = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
        bcd_next = {hi_corr[2:0], lo_corr, bin_q[WIDTH-1]};

        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        tens_d  = tens_q;
        ones_d  = ones_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    bin_d   = value;
                    bcd_d   = 8'd0;
                    count_d = 3'(WIDTH);
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            SHIFT: begin
                bcd_d   = bcd_next;
                bin_d   = bin_q << 1;
                count_d = count_q - 3'd1;
                if (count_q == 3'd1) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                    tens_d  = bcd_next[7:4];
                    ones_d  = bcd_next[3:0];
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= 8'd0;
            count_q <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign valid = valid_q;
    assign tens  = tens_q;
    assign ones  = ones_q;

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Bench for bcd_serial_converter: a 6-bit and a 4-bit instance checked
// against value/10 and value%10 through expected-result queues.
module tb_bcd_serial_converter;

  logic       clock = 1'b0;
  logic       reset;
  logic       start6, start4;
  logic [5:0] value6;
  logic [3:0] value4;
  logic       busy6, done6, valid6;
  logic       busy4, done4, valid4;
  logic [3:0] tens6, ones6, tens4, ones4;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp6_q[$];
  logic [7:0] exp4_q[$];
  logic [7:0] e6, e4;

  typedef struct {
    logic [5:0] value;
    logic [3:0] tens;
    logic [3:0] ones;
  } vec_t;

  vec_t vecs[8];

  always #5 clock = ~clock;

  bcd_serial_converter #(.WIDTH(6)) dut6 (
    .clock(clock), .reset(reset), .start(start6), .value(value6),
    .busy(busy6), .done(done6), .valid(valid6), .tens(tens6), .ones(ones6)
  );

  bcd_serial_converter #(.WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .value(value4),
    .busy(busy4), .done(done4), .valid(valid4), .tens(tens4), .ones(ones4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: pop one expected result per done pulse
  always @(negedge clock) begin
    if (!reset && done6) begin
      if (exp6_q.size() == 0) check("sb6 unexpected done", 1, 0);
      else begin
        e6 = exp6_q.pop_front();
        check("sb6 tens", tens6, e6[7:4]);
        check("sb6 ones", ones6, e6[3:0]);
        check("sb6 valid", valid6, 1);
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && done4) begin
      if (exp4_q.size() == 0) check("sb4 unexpected done", 1, 0);
      else begin
        e4 = exp4_q.pop_front();
        check("sb4 tens", tens4, e4[7:4]);
        check("sb4 ones", ones4, e4[3:0]);
        check("sb4 valid", valid4, 1);
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after a rising edge.
  task automatic convert6(input logic [5:0] v);
    int lat;
    start6 = 1'b1;
    value6 = v;
    exp6_q.push_back({4'(v / 10), 4'(v % 10)});
    @(posedge clock); #1;
    start6 = 1'b0;
    value6 = 6'($urandom_range(0, 63));
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock); #1;
      if (done6) begin
        lat = c;
        break;
      end
      check("busy6 during shift", busy6, 1);
    end
    check("latency6", lat, 6);
    check("busy6 at done", busy6, 0);
    @(posedge clock); #1;
    check("done6 one cycle", done6, 0);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic convert4(input logic [3:0] v);
    int lat;
    start4 = 1'b1;
    value4 = v;
    exp4_q.push_back({4'(v / 10), 4'(v % 10)});
    @(posedge clock); #1;
    start4 = 1'b0;
    value4 = 4'($urandom_range(0, 15));
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock); #1;
      if (done4) begin
        lat = c;
        break;
      end
      check("busy4 during shift", busy4, 1);
    end
    check("latency4", lat, 4);
    @(posedge clock); #1;
    check("done4 one cycle", done4, 0);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    int n_done;
    int t_first;
    int t_second;

    vecs[0] = '{6'd63, 4'd6, 4'd3};
    vecs[1] = '{6'd0,  4'd0, 4'd0};
    vecs[2] = '{6'd10, 4'd1, 4'd0};
    vecs[3] = '{6'd9,  4'd0, 4'd9};
    vecs[4] = '{6'd45, 4'd4, 4'd5};
    vecs[5] = '{6'd19, 4'd1, 4'd9};
    vecs[6] = '{6'd50, 4'd5, 4'd0};
    vecs[7] = '{6'd1,  4'd0, 4'd1};

    // clock/reset
    reset  = 1'b1;
    start6 = 1'b0;
    start4 = 1'b0;
    value6 = 6'd0;
    value4 = 4'd0;
    repeat (2) @(posedge clock);
    #1;
    check("reset busy", busy6, 0);
    check("reset done", done6, 0);
    check("reset valid", valid6, 0);
    check("reset tens", tens6, 0);
    check("reset ones", ones6, 0);
    check("reset valid4", valid4, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // table-driven vectors
    for (int i = 0; i < 8; i++) begin
      convert6(vecs[i].value);
      check("table tens", tens6, vecs[i].tens);
      check("table ones", ones6, vecs[i].ones);
      check("table valid", valid6, 1);
    end

    // start during SHIFT is ignored; value change after capture has no effect
    start6 = 1'b1;
    value6 = 6'd45;
    exp6_q.push_back({4'd4, 4'd5});
    @(posedge clock); #1;
    start6 = 1'b0;
    value6 = 6'd7;
    @(posedge clock); #1;
    start6 = 1'b1;
    @(posedge clock); #1;
    start6 = 1'b0;
    n_done = 0;
    t_first = 0;
    for (int c = 3; c <= 16; c++) begin
      @(posedge clock); #1;
      if (done6) begin
        n_done++;
        t_first = c;
      end
    end
    check("ignored start done count", n_done, 1);
    check("ignored start done time", t_first, 6);
    check("ignored start tens", tens6, 4);
    check("ignored start ones", ones6, 5);

    // back-to-back with start held high
    start6 = 1'b1;
    value6 = 6'd27;
    exp6_q.push_back({4'd2, 4'd7});
    exp6_q.push_back({4'd5, 4'd8});
    @(posedge clock); #1;
    value6 = 6'd58;
    n_done = 0;
    t_first = 0;
    t_second = 0;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clock); #1;
      if (c == 7) start6 = 1'b0;
      if (done6) begin
        n_done++;
        if (n_done == 1) t_first = c;
        else t_second = c;
      end
    end
    check("b2b done count", n_done, 2);
    check("b2b first done", t_first, 6);
    check("b2b spacing", t_second - t_first, 7);
    check("b2b tens", tens6, 5);
    check("b2b ones", ones6, 8);

    // reset during a conversion discards it
    start6 = 1'b1;
    value6 = 6'd63;
    exp6_q.push_back({4'd6, 4'd3});
    @(posedge clock); #1;
    start6 = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    check("midreset busy", busy6, 0);
    check("midreset done", done6, 0);
    check("midreset valid", valid6, 0);
    check("midreset tens", tens6, 0);
    check("midreset ones", ones6, 0);
    reset = 1'b0;
    exp6_q.delete();
    exp4_q.delete();
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      if (done6) n_done++;
    end
    check("midreset no done", n_done, 0);
    check("midreset busy after", busy6, 0);

    // exhaustive sweeps
    for (int v = 0; v < 64; v++) begin
      convert6(6'(v));
      check("sweep6 tens", tens6, v / 10);
      check("sweep6 ones", ones6, v % 10);
    end
    for (int v = 0; v < 16; v++) begin
      convert4(4'(v));
      check("sweep4 tens", tens4, v / 10);
      check("sweep4 ones", ones4, v % 10);
    end

    repeat (3) @(posedge clock);
    #1;
    check("sb6 drained", exp6_q.size(), 0);
    check("sb4 drained", exp4_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
